// File: rtl/id_ex_stage.sv
// ID/EX pipeline register: captures decoded operands and control, detects load-use
// hazards, inserts bubbles, precomputes EX forwarding selects and counts stall cycles.
module id_ex_stage #(
   parameter int          DATA_W        = 32,
   parameter int          CTRL_W        = 8,
   parameter logic [15:0] STALL_PRELOAD = 16'h0000
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              id_valid,
   input  logic [4:0]        id_rs,
   input  logic [4:0]        id_rt,
   input  logic [4:0]        id_rd,
   input  logic              id_uses_rt,
   input  logic [DATA_W-1:0] id_rs_data,
   input  logic [DATA_W-1:0] id_rt_data,
   input  logic [DATA_W-1:0] id_imm,
   input  logic [CTRL_W-1:0] id_ctrl,
   input  logic [4:0]        mem_rd,
   input  logic              mem_reg_write,
   input  logic              flush,
   output logic              ex_valid,
   output logic [CTRL_W-1:0] ex_ctrl,
   output logic [DATA_W-1:0] ex_rs_data,
   output logic [DATA_W-1:0] ex_rt_data,
   output logic [DATA_W-1:0] ex_imm,
   output logic [4:0]        ex_rs,
   output logic [4:0]        ex_rt,
   output logic [4:0]        ex_rd,
   output logic [1:0]        ex_fwd_a,
   output logic [1:0]        ex_fwd_b,
   output logic              stall_out,
   output logic [15:0]       stall_count
);

   logic              valid_p1;
   logic [CTRL_W-1:0] ctrl_p1;
   logic [DATA_W-1:0] rs_data_p1;
   logic [DATA_W-1:0] rt_data_p1;
   logic [DATA_W-1:0] imm_p1;
   logic [4:0]        rs_p1;
   logic [4:0]        rt_p1;
   logic [4:0]        rd_p1;
   logic [1:0]        fwd_a_p1;
   logic [1:0]        fwd_b_p1;
   logic [15:0]       stall_cnt_p1;

   logic              hazard;
   logic              bubble;
   logic              exmem_ok;
   logic              memwb_ok;
   logic [1:0]        fwd_a_d;
   logic [1:0]        fwd_b_d;

   function automatic logic [15:0] sat_inc(input logic [15:0] v);
      return (v == 16'hFFFF) ? v : v + 16'd1;
   endfunction

   // EX/MEM producer outranks MEM/WB because it holds the younger value.
   function automatic logic [1:0] fwd_sel(input logic [4:0] src,
                                          input logic       ex_ok,
                                          input logic [4:0] ex_dst,
                                          input logic       mem_ok,
                                          input logic [4:0] mem_dst);
      if (ex_ok && (ex_dst == src))
         return 2'b10;
      else if (mem_ok && (mem_dst == src))
         return 2'b01;
      else
         return 2'b00;
   endfunction

   always_comb begin
      hazard    = id_valid & valid_p1 & ctrl_p1[1] & (rd_p1 != 5'd0) &
                  ((rd_p1 == id_rs) | (id_uses_rt & (rd_p1 == id_rt)));
      stall_out = hazard & ~flush;
      bubble    = flush | hazard | ~id_valid;
      exmem_ok  = valid_p1 & ctrl_p1[0] & (rd_p1 != 5'd0);
      memwb_ok  = mem_reg_write & (mem_rd != 5'd0);
      fwd_a_d   = fwd_sel(id_rs, exmem_ok, rd_p1, memwb_ok, mem_rd);
      fwd_b_d   = id_uses_rt ? fwd_sel(id_rt, exmem_ok, rd_p1, memwb_ok, mem_rd) : 2'b00;
   end

   // ---- ID -> EX boundary ----
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         valid_p1   <= 1'b0;
         ctrl_p1    <= '0;
         rs_data_p1 <= '0;
         rt_data_p1 <= '0;
         imm_p1     <= '0;
         rs_p1      <= '0;
         rt_p1      <= '0;
         rd_p1      <= '0;
         fwd_a_p1   <= 2'b00;
         fwd_b_p1   <= 2'b00;
      end else if (bubble) begin
         valid_p1   <= 1'b0;
         ctrl_p1    <= '0;
         rs_data_p1 <= '0;
         rt_data_p1 <= '0;
         imm_p1     <= '0;
         rs_p1      <= '0;
         rt_p1      <= '0;
         rd_p1      <= '0;
         fwd_a_p1   <= 2'b00;
         fwd_b_p1   <= 2'b00;
      end else begin
         valid_p1   <= 1'b1;
         ctrl_p1    <= id_ctrl;
         rs_data_p1 <= id_rs_data;
         rt_data_p1 <= id_rt_data;
         imm_p1     <= id_imm;
         rs_p1      <= id_rs;
         rt_p1      <= id_rt;
         rd_p1      <= id_rd;
         fwd_a_p1   <= fwd_a_d;
         fwd_b_p1   <= fwd_b_d;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset)
         stall_cnt_p1 <= STALL_PRELOAD;
      else if (stall_out)
         stall_cnt_p1 <= sat_inc(stall_cnt_p1);
   end

   assign ex_valid    = valid_p1;
   assign ex_ctrl     = ctrl_p1;
   assign ex_rs_data  = rs_data_p1;
   assign ex_rt_data  = rt_data_p1;
   assign ex_imm      = imm_p1;
   assign ex_rs       = rs_p1;
   assign ex_rt       = rt_p1;
   assign ex_rd       = rd_p1;
   assign ex_fwd_a    = fwd_a_p1;
   assign ex_fwd_b    = fwd_b_p1;
   assign stall_count = stall_cnt_p1;

endmodule

// File: tb/tb_id_ex_stage.sv
// Bench for id_ex_stage: directed scenarios then random traffic against a behavioural model.
module tb_id_ex_stage;

   localparam logic [15:0] PRE = 16'hFFF0;

   logic        clk, reset;
   logic        id_valid, id_uses_rt, mem_reg_write, flush;
   logic [4:0]  id_rs, id_rt, id_rd, mem_rd;
   logic [31:0] id_rs_data, id_rt_data, id_imm;
   logic [7:0]  id_ctrl;

   logic        ex_valid, stall_out, s_ex_valid, s_stall_out;
   logic [7:0]  ex_ctrl, s_ex_ctrl;
   logic [31:0] ex_rs_data, ex_rt_data, ex_imm, s_ex_rs_data, s_ex_rt_data, s_ex_imm;
   logic [4:0]  ex_rs, ex_rt, ex_rd, s_ex_rs, s_ex_rt, s_ex_rd;
   logic [1:0]  ex_fwd_a, ex_fwd_b, s_ex_fwd_a, s_ex_fwd_b;
   logic [15:0] stall_count, s_stall_count;

   int checks = 0;
   int errors = 0;

   id_ex_stage dut (
      .clk(clk), .reset(reset), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
      .id_rd(id_rd), .id_uses_rt(id_uses_rt), .id_rs_data(id_rs_data),
      .id_rt_data(id_rt_data), .id_imm(id_imm), .id_ctrl(id_ctrl), .mem_rd(mem_rd),
      .mem_reg_write(mem_reg_write), .flush(flush), .ex_valid(ex_valid),
      .ex_ctrl(ex_ctrl), .ex_rs_data(ex_rs_data), .ex_rt_data(ex_rt_data),
      .ex_imm(ex_imm), .ex_rs(ex_rs), .ex_rt(ex_rt), .ex_rd(ex_rd),
      .ex_fwd_a(ex_fwd_a), .ex_fwd_b(ex_fwd_b), .stall_out(stall_out),
      .stall_count(stall_count)
   );

   // Second instance with a preloaded counter so saturation is reachable quickly.
   id_ex_stage #(.STALL_PRELOAD(PRE)) dut_sat (
      .clk(clk), .reset(reset), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
      .id_rd(id_rd), .id_uses_rt(id_uses_rt), .id_rs_data(id_rs_data),
      .id_rt_data(id_rt_data), .id_imm(id_imm), .id_ctrl(id_ctrl), .mem_rd(mem_rd),
      .mem_reg_write(mem_reg_write), .flush(flush), .ex_valid(s_ex_valid),
      .ex_ctrl(s_ex_ctrl), .ex_rs_data(s_ex_rs_data), .ex_rt_data(s_ex_rt_data),
      .ex_imm(s_ex_imm), .ex_rs(s_ex_rs), .ex_rt(s_ex_rt), .ex_rd(s_ex_rd),
      .ex_fwd_a(s_ex_fwd_a), .ex_fwd_b(s_ex_fwd_b), .stall_out(s_stall_out),
      .stall_count(s_stall_count)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #2000000;
      $display("FAIL timeout: simulation did not complete");
      $fatal(1, "timeout");
   end

   typedef struct packed {
      logic        valid;
      logic [7:0]  ctrl;
      logic [31:0] rsd, rtd, imm;
      logic [4:0]  rs, rt, rd;
      logic [1:0]  fa, fb;
   } ex_t;

   ex_t m;
   int  cnt, cnt_sat;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Instruction in EX is a load into a nonzero register that the decoded instruction reads.
   function automatic logic model_hazard();
      logic load_pending, reads;
      load_pending = m.valid && m.ctrl[1] && (m.rd != 0);
      reads        = (m.rd == id_rs) || (id_uses_rt && (m.rd == id_rt));
      return id_valid && load_pending && reads;
   endfunction

   function automatic logic [1:0] src_of(input logic [4:0] r);
      if (r == 0) return 2'b00;
      if (m.valid && m.ctrl[0] && (m.rd == r)) return 2'b10;
      if (mem_reg_write && (mem_rd == r)) return 2'b01;
      return 2'b00;
   endfunction

   function automatic int sat16(input int v);
      return (v >= 65535) ? 65535 : v + 1;
   endfunction

   task automatic check_all();
      chk("ex_valid", ex_valid, m.valid);
      chk("ex_ctrl", ex_ctrl, m.ctrl);
      chk("ex_rs_data", ex_rs_data, m.rsd);
      chk("ex_rt_data", ex_rt_data, m.rtd);
      chk("ex_imm", ex_imm, m.imm);
      chk("ex_rs", ex_rs, m.rs);
      chk("ex_rt", ex_rt, m.rt);
      chk("ex_rd", ex_rd, m.rd);
      chk("ex_fwd_a", ex_fwd_a, m.fa);
      chk("ex_fwd_b", ex_fwd_b, m.fb);
      chk("stall_count", stall_count, cnt);
      chk("sat_stall_count", s_stall_count, cnt_sat);
      chk("sat_ex_valid", s_ex_valid, m.valid);
   endtask

   task automatic cycle();
      ex_t  nx;
      logic haz, st;
      #1;
      haz = model_hazard();
      st  = haz && !flush;
      chk("stall_out", stall_out, st);
      nx = '0;
      if (!(flush || haz || !id_valid)) begin
         nx.valid = 1'b1;
         nx.ctrl  = id_ctrl;
         nx.rsd   = id_rs_data;
         nx.rtd   = id_rt_data;
         nx.imm   = id_imm;
         nx.rs    = id_rs;
         nx.rt    = id_rt;
         nx.rd    = id_rd;
         nx.fa    = src_of(id_rs);
         nx.fb    = id_uses_rt ? src_of(id_rt) : 2'b00;
      end
      @(posedge clk);
      #1;
      m = nx;
      if (st) begin
         cnt     = sat16(cnt);
         cnt_sat = sat16(cnt_sat);
      end
      check_all();
   endtask

   task automatic set_id(input logic v, input logic [4:0] rs, input logic [4:0] rt,
                         input logic [4:0] rd, input logic ur, input logic [7:0] c);
      id_valid   = v;
      id_rs      = rs;
      id_rt      = rt;
      id_rd      = rd;
      id_uses_rt = ur;
      id_ctrl    = c;
      id_rs_data = $urandom;
      id_rt_data = $urandom;
      id_imm     = $urandom;
   endtask

   task automatic model_reset();
      m       = '0;
      cnt     = 0;
      cnt_sat = PRE;
   endtask

   initial begin
      int c0;
      reset = 1'b0;
      flush = 1'b0;
      mem_rd = 5'd0;
      mem_reg_write = 1'b0;
      set_id(1'b1, 5'd3, 5'd4, 5'd5, 1'b1, 8'h03);
      model_reset();
      repeat (2) @(posedge clk);
      #1;
      check_all();
      chk("reset_stall_out", stall_out, 1'b0);
      reset = 1'b1;

      // Load-use: one stall, then capture with MEM/WB forward.
      set_id(1'b1, 5'd1, 5'd2, 5'd5, 1'b0, 8'h03);
      cycle();
      set_id(1'b1, 5'd5, 5'd6, 5'd9, 1'b1, 8'h01);
      #1;
      chk("lu_stall", stall_out, 1'b1);
      cycle();
      chk("lu_bubble_valid", ex_valid, 1'b0);
      mem_rd = 5'd5;
      mem_reg_write = 1'b1;
      #1;
      chk("lu_stall_clear", stall_out, 1'b0);
      cycle();
      chk("lu_valid", ex_valid, 1'b1);
      chk("lu_fwd_a", ex_fwd_a, 2'b01);
      chk("lu_fwd_b", ex_fwd_b, 2'b00);
      chk("lu_count", stall_count, 16'd1);

      // Forward priority: EX/MEM beats MEM/WB on both operands.
      mem_reg_write = 1'b0;
      set_id(1'b1, 5'd1, 5'd2, 5'd7, 1'b1, 8'h01);
      cycle();
      set_id(1'b1, 5'd7, 5'd7, 5'd3, 1'b1, 8'h01);
      mem_rd = 5'd7;
      mem_reg_write = 1'b1;
      #1;
      chk("prio_stall", stall_out, 1'b0);
      cycle();
      chk("prio_fwd_a", ex_fwd_a, 2'b10);
      chk("prio_fwd_b", ex_fwd_b, 2'b10);

      // r0 guard.
      mem_reg_write = 1'b0;
      set_id(1'b1, 5'd1, 5'd2, 5'd0, 1'b0, 8'h03);
      cycle();
      set_id(1'b1, 5'd0, 5'd4, 5'd8, 1'b0, 8'h01);
      #1;
      chk("r0_stall", stall_out, 1'b0);
      cycle();
      chk("r0_fwd_a", ex_fwd_a, 2'b00);
      chk("r0_valid", ex_valid, 1'b1);

      // Flush over stall.
      set_id(1'b1, 5'd1, 5'd2, 5'd5, 1'b0, 8'h03);
      cycle();
      set_id(1'b1, 5'd5, 5'd6, 5'd9, 1'b1, 8'h01);
      flush = 1'b1;
      c0 = cnt;
      #1;
      chk("flush_stall", stall_out, 1'b0);
      cycle();
      chk("flush_valid", ex_valid, 1'b0);
      chk("flush_count", stall_count, c0);
      flush = 1'b0;

      // Saturation on the preloaded instance.
      for (int i = 0; i < 20; i++) begin
         set_id(1'b1, 5'd1, 5'd2, 5'd5, 1'b0, 8'h03);
         cycle();
         set_id(1'b1, 5'd5, 5'd6, 5'd9, 1'b1, 8'h01);
         cycle();
      end
      chk("sat_hold", s_stall_count, 16'hFFFF);
      chk("main_count", stall_count, 16'd21);

      // Mid-stream asynchronous reset, then normal capture on the first edge after release.
      set_id(1'b1, 5'd1, 5'd2, 5'd5, 1'b0, 8'h03);
      cycle();
      set_id(1'b1, 5'd5, 5'd6, 5'd9, 1'b1, 8'h01);
      reset = 1'b0;
      #1;
      model_reset();
      check_all();
      chk("midrst_stall", stall_out, 1'b0);
      @(posedge clk);
      #1;
      check_all();
      reset = 1'b1;
      set_id(1'b1, 5'd5, 5'd6, 5'd7, 1'b1, 8'h03);
      cycle();
      chk("release_valid", ex_valid, 1'b1);

      // Random traffic on a small register set to provoke hazards and forwards.
      for (int i = 0; i < 3000; i++) begin
         set_id($urandom_range(0, 7) != 0, 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
                5'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), 8'($urandom));
         mem_rd        = 5'($urandom_range(0, 3));
         mem_reg_write = 1'($urandom_range(0, 1));
         flush         = ($urandom_range(0, 9) == 0);
         cycle();
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
